seq_divider: RTL and testbench

Sequential restoring divider that undoes the 4x4 arithmetic unit's multiply path. It takes an 8-bit product-width dividend and a 4-bit divisor and returns an 8-bit quotient and a 4-bit remainder, one quotient bit per clock. A start/busy/done handshake connects it to the same operand sources and result consumers as the arithmetic unit.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_step.sv | 36 +++
 rtl/seq_divider.sv | 127 ++++++++++++
 tb/tb_seq_divider.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// ============================================================================
// Module      : div_pkg
// Description : Shared state encoding and default widths for seq_divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int DEF_N  = 4;
    localparam int DEF_W2 = 2 * DEF_N;
    localparam int DEF_WR = DEF_N + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division iteration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step
    import div_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N:0]   rem_i,
    input  logic         bit_i,
    input  logic [N-1:0] divisor_i,
    output logic [N:0]   rem_o,
    output logic         qbit_o
);

    logic [N:0] w_t;
    logic [N:0] w_dvs;
    logic       w_ge;
    logic       w_unused_rem_msb;

    // The partial remainder is always below the divisor, so its MSB is never set.
    assign w_unused_rem_msb = rem_i[N];

    assign w_t    = {rem_i[N-1:0], bit_i};
    assign w_dvs  = {1'b0, divisor_i};
    assign w_ge   = (w_t >= w_dvs);
    assign rem_o  = w_ge ? (w_t - w_dvs) : w_t;
    assign qbit_o = w_ge;

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module      : seq_divider
// Description : Sequential restoring divider, 2N-bit / N-bit, one bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider
    import div_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             div_by_zero
);

    localparam int W2 = 2 * N;
    localparam int CW = $clog2(W2) + 1;
    localparam logic [CW-1:0] C_LAST = CW'(W2 - 1);

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [W2-1:0]   dvd_q;
    logic [N-1:0]    dvs_q;
    logic [N:0]      rem_q;
    logic [W2-1:0]   quo_q;
    logic            busy_q;
    logic            done_q;
    logic [W2-1:0]   quotient_q;
    logic [N-1:0]    remainder_q;
    logic            dbz_q;

    logic [N:0]      w_rem;
    logic            w_qbit;
    logic            w_unused_quo_msb;

    assign w_unused_quo_msb = quo_q[W2-1];

    div_step #(.N(N)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[W2-1]),
        .divisor_i (dvs_q),
        .rem_o     (w_rem),
        .qbit_o    (w_qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        dvd_q  <= dividend;
                        dvs_q  <= divisor;
                        rem_q  <= '0;
                        quo_q  <= '0;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (divisor == '0) begin
                            // Divide-by-zero skips the iterations entirely.
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= '0;
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    dvd_q <= {dvd_q[W2-2:0], 1'b0};
                    rem_q <= w_rem;
                    quo_q <= {quo_q[W2-2:0], w_qbit};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == C_LAST) begin
                        // Results of the final iteration go straight to the outputs.
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        quotient_q  <= {quo_q[W2-2:0], w_qbit};
                        remainder_q <= w_rem[N-1:0];
                        dbz_q       <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// Module      : tb_seq_divider
// Description : Scoreboard testbench for seq_divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;

    localparam int N  = 4;
    localparam int W2 = 2 * N;

    typedef struct {
        logic [W2-1:0] a;
        logic [N-1:0]  b;
        logic [W2-1:0] q;
        logic [N-1:0]  r;
        logic          dbz;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W2-1:0] dividend;
    logic [N-1:0]  divisor;
    logic          busy;
    logic          done;
    logic [W2-1:0] quotient;
    logic [N-1:0]  remainder;
    logic          div_by_zero;

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    exp_t sb[$];

    bit            pre_start = 1'b0;
    bit            pre_busy  = 1'b0;
    bit            pre_rst   = 1'b1;
    logic [W2-1:0] pre_a     = '0;
    logic [N-1:0]  pre_b     = '0;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        pre_start = start;
        pre_busy  = busy;
        pre_rst   = rst;
        pre_a     = dividend;
        pre_b     = divisor;
    end

    // Acceptance is start seen while not busy; results are checked on done.
    always @(posedge clk) begin
        exp_t e;
        exp_t g;
        cyc++;
        if (!pre_rst && !rst && pre_start && !pre_busy) begin
            e.a = pre_a;
            e.b = pre_b;
            if (pre_b == '0) begin
                e.q   = '1;
                e.r   = '0;
                e.dbz = 1'b1;
                e.due = cyc;
            end else begin
                e.q   = pre_a / W2'(pre_b);
                e.r   = N'(pre_a % W2'(pre_b));
                e.dbz = 1'b0;
                e.due = cyc + W2;
            end
            sb.push_back(e);
        end
        #1;
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 0);
            end else begin
                g = sb.pop_front();
                chk("quotient", 32'(quotient), 32'(g.q));
                chk("remainder", 32'(remainder), 32'(g.r));
                chk("div_by_zero", 32'(div_by_zero), 32'(g.dbz));
                chk("done_latency", 32'(cyc), 32'(g.due));
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 40 && (busy || done); i++) begin
            @(posedge clk);
            #2;
        end
        chk("idle_wait", {30'd0, busy, done}, 0);
    endtask

    // Caller is 2 time units after a rising edge with the DUT idle.
    task automatic issue(input logic [W2-1:0] a, input logic [N-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #2;
        start    = 1'b0;
        dividend = W2'($urandom);
        divisor  = N'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int bc;
        int n_done;
        int last;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_quotient", 32'(quotient), 0);
        chk("rst_remainder", 32'(remainder), 0);
        chk("rst_dbz", 32'(div_by_zero), 0);
        rst = 1'b0;
        @(posedge clk);
        #2;

        // 200 / 7, busy window length
        issue(8'd200, 4'd7);
        bc = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            bc++;
            @(posedge clk);
            #2;
        end
        chk("busy_cycles", 32'(bc), 9);
        chk("hold_q_200_7", 32'(quotient), 28);
        chk("hold_r_200_7", 32'(remainder), 4);

        // Boundary operand pairs and result hold
        wait_idle();
        issue(8'd255, 4'd1);
        wait_idle();
        issue(8'd5, 4'd9);
        wait_idle();
        repeat (5) @(posedge clk);
        #2;
        chk("hold_q_5_9", 32'(quotient), 0);
        chk("hold_r_5_9", 32'(remainder), 5);
        issue(8'd225, 4'd15);
        wait_idle();

        // Divide by zero, then the flag clears
        issue(8'd90, 4'd0);
        wait_idle();
        chk("hold_dbz", 32'(div_by_zero), 1);
        chk("hold_q_dbz", 32'(quotient), 255);
        issue(8'd90, 4'd10);
        wait_idle();
        chk("dbz_cleared", 32'(div_by_zero), 0);

        // start held high: one done every 10 cycles
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 4'd3;
        n_done   = 0;
        last     = -1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #2;
            if (done) begin
                if (last >= 0) chk("b2b_spacing", 32'(cyc - last), 10);
                last = cyc;
                n_done++;
            end
        end
        start = 1'b0;
        wait_idle();
        chk("b2b_count", 32'(n_done), 3);
        issue(8'd100, 4'd3);
        wait_idle();

        // Reset in the 4th RUN cycle aborts with no done
        issue(8'd200, 4'd7);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_quotient", 32'(quotient), 0);
        chk("abort_remainder", 32'(remainder), 0);
        chk("abort_dbz", 32'(div_by_zero), 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        issue(8'd17, 4'd4);
        wait_idle();
        chk("after_abort_q", 32'(quotient), 4);
        chk("after_abort_r", 32'(remainder), 1);

        // Exhaustive nonzero-divisor sweep
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                issue(W2'(a), N'(b));
                wait_idle();
            end
        end

        chk("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
